// File: rtl/mio_pkg.sv
// Shared constants and types for the CPU memory/IO bus controller.
package mio_pkg;
  localparam logic [31:0] SEG_ADDR = 32'hE000_0000;
  localparam logic [31:0] IO_ADDR  = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR = 32'hF000_0004;
  localparam int          WAIT_W   = 4;

  typedef enum logic [2:0] {R_RAM, R_SEG, R_IO, R_CNT, R_ERR} region_t;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/mio_sync.sv
// Two-flop synchronizer for asynchronous board inputs.
module mio_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= '0;
    else       {q, meta} <= {meta, d};
endmodule

// File: rtl/mio_bus.sv
// Memory/IO bus controller: decodes CPU word requests to RAM or peripheral
// registers and returns the Moore-style mio_ready handshake.
module mio_bus
  import mio_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              cpu_mio,
  output logic              mio_ready,
  output logic [31:0]       cpu_rdata,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  input  logic [3:0]        btn_in,
  output logic [15:0]       led_out,
  output logic [31:0]       seg_out
);
  state_t             state;
  region_t            region, region_q;
  logic               is_wr;
  logic [WAIT_W-1:0]  wcnt;
  logic [31:0]        count;
  logic               cnt_load;
  logic [15:0]        sw_sync;
  logic [3:0]         btn_sync;
  logic               unused_addr;

  assign unused_addr = ^cpu_addr[1:0];

  mio_sync #(.W(16)) u_sw  (.clk(clk), .reset(reset), .d(sw_in),  .q(sw_sync));
  mio_sync #(.W(4))  u_btn (.clk(clk), .reset(reset), .d(btn_in), .q(btn_sync));

  // A request with both directions set is treated as an error access.
  always_comb begin
    region = R_ERR;
    if (mem_read & mem_write)                        region = R_ERR;
    else if (cpu_addr[31:RAM_AW+2] == '0)            region = R_RAM;
    else if (cpu_addr[31:2] == SEG_ADDR[31:2])       region = R_SEG;
    else if (cpu_addr[31:2] == IO_ADDR[31:2])        region = R_IO;
    else if (cpu_addr[31:2] == CNT_ADDR[31:2])       region = R_CNT;
  end

  assign cnt_load = (state == S_ACCESS) && is_wr && (region_q == R_CNT);

  always_ff @(posedge clk or posedge reset)
    if (reset)         count <= '0;
    else if (cnt_load) count <= ram_din;
    else               count <= count + 32'd1;

  // ram_din doubles as the latched write data for peripheral writes.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= S_IDLE;
      mio_ready <= 1'b0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      led_out   <= '0;
      seg_out   <= '0;
      region_q  <= R_ERR;
      is_wr     <= 1'b0;
      wcnt      <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (cpu_mio & (mem_read | mem_write)) begin
            region_q <= region;
            is_wr    <= mem_write & ~mem_read;
            ram_addr <= cpu_addr[RAM_AW+1:2];
            ram_din  <= cpu_wdata;
            ram_we   <= (region == R_RAM) & mem_write & ~mem_read;
            state    <= S_ACCESS;
          end
        S_ACCESS: begin
          ram_we <= 1'b0;
          if (region_q == R_ERR) bus_err <= 1'b1;
          if (is_wr) begin
            case (region_q)
              R_SEG:   seg_out <= ram_din;
              R_IO:    led_out <= ram_din[15:0];
              default: ;
            endcase
          end else begin
            case (region_q)
              R_SEG:   cpu_rdata <= seg_out;
              R_IO:    cpu_rdata <= {12'b0, btn_sync, sw_sync};
              R_CNT:   cpu_rdata <= count;
              R_ERR:   cpu_rdata <= '0;
              default: ;
            endcase
          end
          if (!is_wr && region_q == R_RAM) begin
            wcnt  <= WAIT_W'(RAM_WAIT);
            state <= S_WAIT;
          end else begin
            mio_ready <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_WAIT:
          if (wcnt == WAIT_W'(1)) begin
            cpu_rdata <= ram_dout;
            mio_ready <= 1'b1;
            state     <= S_DONE;
          end else begin
            wcnt <= wcnt - WAIT_W'(1);
          end
        S_DONE:
          if (!cpu_mio) begin
            mio_ready <= 1'b0;
            state     <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mio_bus.sv
// Directed bench: two controllers (RAM_WAIT 1 and 3) share CPU stimulus,
// each backed by its own synchronous RAM model.
module tb_mio_bus;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        mem_read, mem_write, cpu_mio;
  logic [15:0] sw_in;
  logic [3:0]  btn_in;

  logic        mio_ready1, bus_err1, ram_we1, mio_ready3, bus_err3, ram_we3;
  logic [31:0] cpu_rdata1, ram_din1, ram_dout1, seg_out1;
  logic [31:0] cpu_rdata3, ram_din3, ram_dout3, seg_out3;
  logic [9:0]  ram_addr1, ram_addr3;
  logic [15:0] led_out1, led_out3;
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];

  int passed = 0, total = 0;
  int lat1, lat3, we1, rdy_hold;
  logic [31:0] weaddr;

  always #5 clk = ~clk;

  mio_bus #(.RAM_AW(10), .RAM_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .cpu_mio(cpu_mio),
    .mio_ready(mio_ready1), .cpu_rdata(cpu_rdata1), .bus_err(bus_err1),
    .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1), .ram_dout(ram_dout1),
    .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out1), .seg_out(seg_out1));

  mio_bus #(.RAM_AW(10), .RAM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .cpu_mio(cpu_mio),
    .mio_ready(mio_ready3), .cpu_rdata(cpu_rdata3), .bus_err(bus_err3),
    .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_we(ram_we3), .ram_dout(ram_dout3),
    .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out3), .seg_out(seg_out3));

  always @(posedge clk) begin
    if (ram_we1) mem1[ram_addr1] <= ram_din1;
    ram_dout1 <= mem1[ram_addr1];
    if (ram_we3) mem3[ram_addr3] <= ram_din3;
    ram_dout3 <= mem3[ram_addr3];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One CPU transaction; latencies count negedges after the request edge.
  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input logic rd, input logic wr, input int hold);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; mem_read = rd; mem_write = wr; cpu_mio = 1'b1;
    lat1 = 0; lat3 = 0; we1 = 0; weaddr = '1; rdy_hold = 0;
    for (int n = 1; n <= 20 && (lat1 == 0 || lat3 == 0); n++) begin
      @(negedge clk);
      if (ram_we1) begin we1++; weaddr = 32'(ram_addr1); end
      if (mio_ready1 && lat1 == 0) lat1 = n;
      if (mio_ready3 && lat3 == 0) lat3 = n;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (ram_we1) we1++;
      rdy_hold = int'(mio_ready1);
    end
    cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    cpu_mio = 1'b0; sw_in = '0; btn_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mio_ready1), 0);
    check("rst_rdata", cpu_rdata1, 0);
    check("rst_err",   32'(bus_err1), 0);
    check("rst_we",    32'(ram_we1), 0);
    check("rst_led",   32'(led_out1), 0);
    check("rst_seg",   seg_out1, 0);
    reset = 1'b0;

    req(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
    check("ramwr_we_cnt", 32'(we1), 1);
    check("ramwr_addr",   weaddr, 4);
    check("ramwr_lat1",   32'(lat1), 2);
    check("ramwr_lat3",   32'(lat3), 2);

    req(32'h0000_0010, 0, 1'b1, 1'b0, 0);
    check("ramrd_data1", cpu_rdata1, 32'hDEAD_BEEF);
    check("ramrd_lat1",  32'(lat1), 3);
    check("ramrd_data3", cpu_rdata3, 32'hDEAD_BEEF);
    check("ramrd_lat3",  32'(lat3), 5);

    req(32'hF000_0000, 32'h0000_A5A5, 1'b0, 1'b1, 0);
    check("led_val",     32'(led_out1), 32'h0000_A5A5);
    check("wr_keeps_rd", cpu_rdata1, 32'hDEAD_BEEF);

    sw_in = 16'h1234; btn_in = 4'h5;
    repeat (3) @(negedge clk);
    req(32'hF000_0000, 0, 1'b1, 1'b0, 0);
    check("io_rd",  cpu_rdata1, 32'h0005_1234);
    check("io_lat", 32'(lat1), 2);

    req(32'hE000_0000, 32'h1234_5678, 1'b0, 1'b1, 0);
    check("seg_out", seg_out1, 32'h1234_5678);
    req(32'hE000_0003, 0, 1'b1, 1'b0, 0);
    check("seg_rd", cpu_rdata1, 32'h1234_5678);

    req(32'hF000_0004, 32'hFFFF_FFFE, 1'b0, 1'b1, 0);
    req(32'hF000_0004, 0, 1'b1, 1'b0, 0);
    check("cnt_wrap", cpu_rdata1, 32'h0000_0001);
    req(32'hF000_0004, 32'h0000_0100, 1'b0, 1'b1, 0);
    req(32'hF000_0004, 0, 1'b1, 1'b0, 0);
    check("cnt_load", cpu_rdata1, 32'h0000_0103);

    req(32'h0000_0020, 32'hCAFE_F00D, 1'b0, 1'b1, 4);
    check("hold_we_cnt", 32'(we1), 1);
    check("hold_ready",  32'(rdy_hold), 1);
    check("hold_idle",   32'(mio_ready1), 0);
    req(32'h0000_0020, 0, 1'b1, 1'b0, 0);
    check("hold_rd", cpu_rdata1, 32'hCAFE_F00D);

    req(32'h8000_0000, 0, 1'b1, 1'b0, 0);
    check("err_rdata", cpu_rdata1, 0);
    check("err_lat",   32'(lat1), 2);
    check("err_flag",  32'(bus_err1), 1);
    req(32'h0000_0010, 0, 1'b1, 1'b0, 0);
    check("err_sticky", 32'(bus_err1), 1);

    // Reset while both controllers sit in WAIT.
    @(negedge clk);
    cpu_addr = 32'h0000_0010; mem_read = 1'b1; mem_write = 1'b0; cpu_mio = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; cpu_mio = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("rstw_ready1", 32'(mio_ready1), 0);
    check("rstw_ready3", 32'(mio_ready3), 0);
    check("rstw_rdata3", cpu_rdata3, 0);
    check("rstw_err",    32'(bus_err1), 0);
    reset = 1'b0;
    req(32'h0000_0010, 0, 1'b1, 1'b0, 0);
    check("rstw_rd3",   cpu_rdata3, 32'hDEAD_BEEF);
    check("rstw_lat3",  32'(lat3), 5);

    req(32'h0000_0010, 32'h1111_1111, 1'b1, 1'b1, 0);
    check("both_we",  32'(we1), 0);
    check("both_err", 32'(bus_err1), 1);
    check("both_lat", 32'(lat1), 2);
    req(32'h0000_0010, 0, 1'b1, 1'b0, 0);
    check("both_noeffect", cpu_rdata1, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mio_bus.md
# mio_bus

Memory/IO bus controller sitting directly downstream of the multi-cycle CPU controller. It accepts the CPU's word-wide memory requests (MemRead/MemWrite qualified by CPU_MIO), decodes the address to on-chip synchronous RAM or a small peripheral register set, and returns read data. It produces the MIO_ready handshake the controller waits on in instruction fetch and memory states.

## Interface
- RAM_AW, 10, RAM word-address width (RAM = 2^RAM_AW words)
- RAM_WAIT, 1, cycles between RAM address issue and data capture (legal range 1..15)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_addr  in  32  byte address from CPU datapath
- cpu_wdata  in  32  write data
- mem_read  in  1  read request
- mem_write  in  1  write request
- cpu_mio  in  1  request valid; qualifies mem_read/mem_write
- mio_ready  out  1  transaction complete; cpu_rdata valid while high
- cpu_rdata  out  32  read data, held until next completed read
- bus_err  out  1  sticky: set on any undecoded or malformed access
- ram_addr  out  RAM_AW  RAM word address
- ram_din  out  32  RAM write data
- ram_we  out  1  RAM write strobe, one cycle per write
- ram_dout  in  32  RAM read data, valid one cycle after ram_addr
- sw_in  in  16  switches, asynchronous
- btn_in  in  4  buttons, asynchronous
- led_out  out  16  LED register
- seg_out  out  32  seven-segment display data register

## Operation
- Address map (cpu_addr[1:0] ignored): RAM when cpu_addr[31:RAM_AW+2]==0, word = cpu_addr[RAM_AW+1:2]; 0xE000_0000 seg register (R/W); 0xF000_0000 read {12'b0, btn_sync, sw_sync}, write led_out[15:0] = wdata[15:0]; 0xF000_0004 cycle counter (read count, write loads count). Anything else: error region.
- Request accepted in IDLE when cpu_mio & (mem_read ^ mem_write). Address, wdata, direction, region latched at acceptance; inputs ignored thereafter until IDLE.
- cpu_mio & mem_read & mem_write: accepted as error access (no side effects).
- States: IDLE, ACCESS, WAIT, DONE.
  - IDLE -> ACCESS on accept.
  - ACCESS (1 cycle): ram_addr/ram_din driven from latched values; ram_we=1 iff RAM write. Peripheral writes commit and peripheral/error reads capture at end of cycle. RAM read -> WAIT (count loaded RAM_WAIT); all else -> DONE.
  - WAIT: count decrements; at end of last WAIT cycle cpu_rdata <= ram_dout, -> DONE.
  - DONE: mio_ready=1 (Moore). -> IDLE when cpu_mio sampled 0; stays in DONE otherwise (no re-issue of a held request).
- Error access: completes normally, read returns 0, writes discarded, bus_err set; cleared only by reset.
- Writes never modify cpu_rdata.
- Counter: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF -> 0; CPU write in same cycle wins (count = wdata, increments from next cycle).
- sw_in/btn_in pass through two-flop synchronizers before being readable.

## Timing
- Reset (async): state IDLE; mio_ready, cpu_rdata, bus_err, ram_addr, ram_din, ram_we, led_out, seg_out, counter all 0; synchronizers 0.
- Reset mid-transaction: immediate return to IDLE, ram_we drops, no uncommitted write takes effect, mio_ready not asserted.
- Request sampled at edge E0: ACCESS is cycle E0..E1.
  - Writes, peripheral and error reads: mio_ready high in cycle E1..E2 (latency 2 edges).
  - RAM reads: mio_ready high in cycle starting at E(1+RAM_WAIT) (default 2+... = 3rd cycle).
- mio_ready stays high until the edge after cpu_mio is sampled low; next request accepted no earlier than the following IDLE cycle.
- Switch change visible to reads after 2 clk edges of synchronizer latency.

## Structure
- Package mio_pkg: address constants (SEG_ADDR, IO_ADDR, CNT_ADDR), region enum (RAM, SEG, IO, CNT, ERR), state enum, RAM_WAIT counter width (4).
- Sub-module mio_sync: parameterized-width two-flop synchronizer, instantiated for sw_in and btn_in.
- Counter, decode, and FSM inline in mio_bus.

## Test plan
- Reset, then RAM write 0xDEADBEEF to 0x0000_0010 -> ram_we one cycle with ram_addr=4, mio_ready in cycle 2; read back -> cpu_rdata=0xDEADBEEF with mio_ready in cycle 3 (RAM_WAIT=1), repeat with RAM_WAIT=3 -> cycle 5.
- Write 0x0000_A5A5 to 0xF000_0000 -> led_out=0xA5A5; sw_in=0x1234, btn_in=0x5, wait 3 cycles, read 0xF000_0000 -> 0x0005_1234.
- Write 0xFFFF_FFFE to 0xF000_0004, read 2 cycles later -> wraps through 0 (value 0x0000_0000 or 0x0000_0001 per exact cycle); write coincident with increment -> loaded value wins.
- Read 0x8000_0000 -> cpu_rdata=0, mio_ready asserted, bus_err=1 and stays 1; mem_read & mem_write together -> no ram_we, bus_err=1.
- Hold cpu_mio high for 4 cycles after mio_ready on a RAM write -> exactly one ram_we pulse, FSM stays in DONE until cpu_mio low.
- Assert reset during WAIT of a RAM read -> mio_ready never asserted, cpu_rdata=0, next request served normally.
